// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding and load-use detection.
// Also used by hazard assertions and the bench.
package hazard_pkg;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    typedef enum logic {
        StRun   = ST_RUN,
        StFlush = ST_FLUSH
    } hazard_state_e;

    // x0 is never a real producer, so a load targeting it cannot create a dependency.
    function automatic logic load_use_detect(
        input logic       mem_read_ex,
        input logic [4:0] rd_ex,
        input logic       uses_rs1_id,
        input logic [4:0] rs1_id,
        input logic       uses_rs2_id,
        input logic [4:0] rs2_id
    );
        return mem_read_ex && (rd_ex != 5'd0) &&
               ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with asynchronous active-high reset.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline stall/flush controller: load-use stalls, mispredict flush sequencing, memory freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             mispredict_ex,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic [CNT_W-1:0] perf_loaduse,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_freeze
);

    localparam int unsigned FlushCntW = $clog2(FLUSH_CYCLES) + 1;

    hazard_state_e        state_q, state_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic                 load_use;

    assign load_use = load_use_detect(mem_read_ex, rd_ex, uses_rs1_id, rs1_id,
                                      uses_rs2_id, rs2_id);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;

        if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mispredict_ex) begin
                        // A same-cycle load-use belongs to the wrong path and is dropped.
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = StFlush;
                            flush_cnt_d = FlushCntW'(FLUSH_CYCLES - 1);
                        end
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                StFlush: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_cnt_d = flush_cnt_q - FlushCntW'(1);
                    if (flush_cnt_q == FlushCntW'(1)) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic ev_loaduse, ev_flush;

    assign ev_loaduse = !mem_busy && (state_q == StRun) && !mispredict_ex && load_use;
    assign ev_flush   = !mem_busy && (state_q == StRun) && mispredict_ex;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_perf_loaduse (
        .clk   (clk),
        .rst   (rst),
        .inc   (ev_loaduse),
        .count (perf_loaduse)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_perf_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (ev_flush),
        .count (perf_flush)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_perf_freeze (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_busy),
        .count (perf_freeze)
    );
`else
    assign perf_loaduse = '0;
    assign perf_flush   = '0;
    assign perf_freeze  = '0;
`endif

endmodule
